// File: rtl/load_queue_if.sv
// Load queue handshake bundle: address-unit allocation, ROB commit/flush,
// data-controller read port and ROB writeback.
// The slave modport is the load queue; master is its environment.
interface load_queue_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ROB_W  = 4
);
  logic              rdy;
  logic              alloc_en;
  logic [ADDR_W-1:0] alloc_addr;
  logic [ROB_W-1:0]  alloc_tag;
  logic [2:0]        alloc_funct3;
  logic              full;
  logic              rob_commit_en;
  logic [ROB_W-1:0]  rob_commit_tag;
  logic              rob_flush;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [2:0]        mem_width;
  logic              mem_done;
  logic [DATA_W-1:0] mem_data;
  logic              wb_en;
  logic [ROB_W-1:0]  wb_tag;
  logic [DATA_W-1:0] wb_value;

  modport slave (
    input  rdy, alloc_en, alloc_addr, alloc_tag, alloc_funct3,
    input  rob_commit_en, rob_commit_tag, rob_flush, mem_done, mem_data,
    output full, mem_req, mem_addr, mem_width, wb_en, wb_tag, wb_value
  );

  modport master (
    output rdy, alloc_en, alloc_addr, alloc_tag, alloc_funct3,
    output rob_commit_en, rob_commit_tag, rob_flush, mem_done, mem_data,
    input  full, mem_req, mem_addr, mem_width, wb_en, wb_tag, wb_value
  );
endinterface

// File: rtl/load_queue.sv
// Circular load queue between the address unit and the data controller.
// Loads issue one at a time once the ROB marks them commit-safe; the returned
// data is sign/zero extended here and written back to the ROB.
// Optional feature macro LQ_OOO_ISSUE_EN: when defined, the oldest ready
// entry anywhere in the queue may issue (holes tracked by valid bits);
// otherwise issue is strictly in order from head.
module load_queue #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned PTR_W  = 3,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ROB_W  = 4
) (
  input logic           clk_in,
  input logic           rst_n_in,
  load_queue_if.slave   bus
);

  localparam logic [PTR_W:0]   FullCnt = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0] PtrOne  = PTR_W'(1);
  localparam logic [PTR_W:0]   CntOne  = (PTR_W + 1)'(1);

  typedef enum logic [1:0] {StIdle, StWait, StDrain} state_e;

  // Entry payload (no reset needed; qualified by valid_q)
  logic [ADDR_W-1:0] addr_q   [DEPTH];
  logic [ROB_W-1:0]  tag_q    [DEPTH];
  logic [2:0]        funct3_q [DEPTH];

  logic [DEPTH-1:0]  valid_q, ready_q;
  logic [PTR_W-1:0]  head_q, tail_q;
  logic [PTR_W:0]    count_q, count_d;
  logic              full_q;
  state_e            state_q;

  // In-flight request
  logic              req_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [2:0]        req_width_q;
  logic [2:0]        req_funct3_q;
  logic [ROB_W-1:0]  req_tag_q;
  logic [PTR_W-1:0]  req_idx_q;

  logic              wb_en_q;
  logic [ROB_W-1:0]  wb_tag_q;
  logic [DATA_W-1:0] wb_value_q;

  logic              alloc_ok, done_fire, flush_fire;
  logic              issue_hit;
  logic [PTR_W-1:0]  issue_idx, scan_idx;

  function automatic logic [2:0] width_of(input logic [2:0] f);
    case (f[1:0])
      2'b00:   return 3'b001;
      2'b01:   return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] extend(input logic [2:0] f,
                                               input logic [DATA_W-1:0] d);
    case (f)
      3'b000:  return {{(DATA_W - 8){d[7]}}, d[7:0]};
      3'b001:  return {{(DATA_W - 16){d[15]}}, d[15:0]};
      3'b100:  return {{(DATA_W - 8){1'b0}}, d[7:0]};
      3'b101:  return {{(DATA_W - 16){1'b0}}, d[15:0]};
      default: return d;
    endcase
  endfunction

  // Per-cycle qualifiers and next occupancy
  always_comb begin
    flush_fire = bus.rdy && bus.rob_flush;
    done_fire  = bus.rdy && !bus.rob_flush && (state_q == StWait) && bus.mem_done;
`ifdef LQ_OOO_ISSUE_EN
    // With holes the tail slot can still be occupied even when count < DEPTH
    alloc_ok   = bus.rdy && !bus.rob_flush && bus.alloc_en && (count_q < FullCnt) &&
                 !valid_q[tail_q];
`else
    alloc_ok   = bus.rdy && !bus.rob_flush && bus.alloc_en && (count_q < FullCnt);
`endif
    count_d = count_q;
    if (flush_fire) begin
      count_d = '0;
    end else begin
      if (alloc_ok)  count_d = count_d + CntOne;
      if (done_fire) count_d = count_d - CntOne;
    end
  end

  // Issue candidate selection
  always_comb begin
    issue_hit = 1'b0;
    issue_idx = head_q;
    scan_idx  = head_q;
`ifdef LQ_OOO_ISSUE_EN
    // Scan youngest to oldest so the oldest ready entry wins
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      scan_idx = head_q + PTR_W'(k);
      if (valid_q[scan_idx] && ready_q[scan_idx]) begin
        issue_hit = 1'b1;
        issue_idx = scan_idx;
      end
    end
`else
    issue_hit = valid_q[head_q] && ready_q[head_q];
`endif
  end

  // Payload write on allocation
  always_ff @(posedge clk_in) begin
    if (alloc_ok) begin
      addr_q[tail_q]   <= bus.alloc_addr;
      tag_q[tail_q]    <= bus.alloc_tag;
      funct3_q[tail_q] <= bus.alloc_funct3;
    end
  end

  // Queue bookkeeping and issue FSM
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= StIdle;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      valid_q      <= '0;
      ready_q      <= '0;
      req_q        <= 1'b0;
      req_addr_q   <= '0;
      req_width_q  <= '0;
      req_funct3_q <= '0;
      req_tag_q    <= '0;
      req_idx_q    <= '0;
      wb_en_q      <= 1'b0;
      wb_tag_q     <= '0;
      wb_value_q   <= '0;
    end else if (!bus.rdy) begin
      wb_en_q <= 1'b0;
    end else begin
      wb_en_q <= 1'b0;
      count_q <= count_d;
      full_q  <= (count_d == FullCnt);

      if (bus.rob_flush) begin
        valid_q <= '0;
        ready_q <= '0;
        head_q  <= '0;
        tail_q  <= '0;
      end else begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          if (valid_q[i] && bus.rob_commit_en && (tag_q[i] == bus.rob_commit_tag)) begin
            ready_q[i] <= 1'b1;
          end
        end
        if (alloc_ok) begin
          valid_q[tail_q] <= 1'b1;
          // A commit for the tag being allocated must not be lost
          ready_q[tail_q] <= bus.rob_commit_en && (bus.rob_commit_tag == bus.alloc_tag);
          tail_q          <= tail_q + PtrOne;
        end
        if (done_fire) begin
          valid_q[req_idx_q] <= 1'b0;
          ready_q[req_idx_q] <= 1'b0;
        end
`ifdef LQ_OOO_ISSUE_EN
        // Lazily step head over freed holes, one slot per cycle
        if ((count_q != '0) && !valid_q[head_q]) head_q <= head_q + PtrOne;
`else
        if (done_fire) head_q <= head_q + PtrOne;
`endif
      end

      case (state_q)
        StIdle: begin
          if (!bus.rob_flush && issue_hit) begin
            req_q        <= 1'b1;
            req_addr_q   <= addr_q[issue_idx];
            req_width_q  <= width_of(funct3_q[issue_idx]);
            req_funct3_q <= funct3_q[issue_idx];
            req_tag_q    <= tag_q[issue_idx];
            req_idx_q    <= issue_idx;
            state_q      <= StWait;
          end
        end
        StWait: begin
          if (bus.mem_done) begin
            req_q   <= 1'b0;
            state_q <= StIdle;
            if (!bus.rob_flush) begin
              wb_en_q    <= 1'b1;
              wb_tag_q   <= req_tag_q;
              wb_value_q <= extend(req_funct3_q, bus.mem_data);
            end
          end else if (bus.rob_flush) begin
            // Request already on the bus: keep it up until it completes
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (bus.mem_done) begin
            req_q   <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.full      = full_q;
  assign bus.mem_req   = req_q;
  assign bus.mem_addr  = req_addr_q;
  assign bus.mem_width = req_width_q;
  assign bus.wb_en     = wb_en_q;
  assign bus.wb_tag    = wb_tag_q;
  assign bus.wb_value  = wb_value_q;

endmodule

// File: tb/tb_load_queue.sv
// Directed cycle-by-cycle vectors for load_queue plus a hand-written
// asynchronous-reset-during-request sequence.
module tb_load_queue;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  load_queue_if #(.ADDR_W(32), .DATA_W(32), .ROB_W(4)) bus ();

  load_queue #(
    .DEPTH(8), .PTR_W(3), .ADDR_W(32), .DATA_W(32), .ROB_W(4)
  ) dut (
    .clk_in(clk),
    .rst_n_in(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic rst, rdy, al;
    logic [31:0] addr;
    logic [3:0] tag;
    logic [2:0] f3;
    logic ce;
    logic [3:0] ct;
    logic fl, dn;
    logic [31:0] data;
  } in_t;

  typedef struct {
    logic full, req;
    logic [31:0] addr;
    logic [2:0] w;
    logic wb;
    logic [3:0] wt;
    logic [31:0] wv;
  } out_t;

  typedef struct {
    string name;
    in_t   i;
    out_t  o;
  } vec_t;

  vec_t vecs[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic in_t IN();
    in_t t;
    t.rst = 0; t.rdy = 1; t.al = 0; t.addr = '0; t.tag = '0; t.f3 = '0;
    t.ce = 0; t.ct = '0; t.fl = 0; t.dn = 0; t.data = '0;
    return t;
  endfunction

  function automatic in_t IR();
    in_t t = IN();
    t.rst = 1;
    return t;
  endfunction

  // Allocate; ce=1 also commits the same tag in the same cycle
  function automatic in_t IA(input logic [3:0] tag, input logic [31:0] addr,
                             input logic [2:0] f3, input logic ce);
    in_t t = IN();
    t.al = 1; t.tag = tag; t.addr = addr; t.f3 = f3; t.ce = ce; t.ct = tag;
    return t;
  endfunction

  function automatic in_t IC(input logic [3:0] tag);
    in_t t = IN();
    t.ce = 1; t.ct = tag;
    return t;
  endfunction

  function automatic in_t ID(input logic [31:0] data);
    in_t t = IN();
    t.dn = 1; t.data = data;
    return t;
  endfunction

  function automatic out_t O0(input logic full);
    out_t o;
    o.full = full; o.req = 0; o.addr = '0; o.w = '0; o.wb = 0; o.wt = '0; o.wv = '0;
    return o;
  endfunction

  function automatic out_t OQ(input logic full, input logic [31:0] addr, input logic [2:0] w);
    out_t o = O0(full);
    o.req = 1; o.addr = addr; o.w = w;
    return o;
  endfunction

  function automatic out_t OW(input logic full, input logic [3:0] tag, input logic [31:0] v);
    out_t o = O0(full);
    o.wb = 1; o.wt = tag; o.wv = v;
    return o;
  endfunction

  task automatic add(input string nm, input in_t i, input out_t o);
    vec_t v;
    v.name = nm; v.i = i; v.o = o;
    vecs.push_back(v);
  endtask

  task automatic drive(input in_t i);
    if (i.rst) rst_n = 1'b0;
    bus.rdy            = i.rdy;
    bus.alloc_en       = i.al;
    bus.alloc_addr     = i.addr;
    bus.alloc_tag      = i.tag;
    bus.alloc_funct3   = i.f3;
    bus.rob_commit_en  = i.ce;
    bus.rob_commit_tag = i.ct;
    bus.rob_flush      = i.fl;
    bus.mem_done       = i.dn;
    bus.mem_data       = i.data;
  endtask

  // addr/width only matter while req is up; wb tag/value only on the pulse
  task automatic check(input string nm, input out_t o);
    logic ok;
    ok = (bus.full === o.full) && (bus.mem_req === o.req) && (bus.wb_en === o.wb);
    if (o.req) ok = ok && (bus.mem_addr === o.addr) && (bus.mem_width === o.w);
    if (o.wb)  ok = ok && (bus.wb_tag === o.wt) && (bus.wb_value === o.wv);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got full=%b req=%b addr=%h w=%b wb=%b tag=%0d val=%h; exp full=%b req=%b addr=%h w=%b wb=%b tag=%0d val=%h",
               nm, bus.full, bus.mem_req, bus.mem_addr, bus.mem_width, bus.wb_en,
               bus.wb_tag, bus.wb_value, o.full, o.req, o.addr, o.w, o.wb, o.wt, o.wv);
    end
  endtask

  task automatic check_all_zero(input string nm);
    n_tests++;
    if (bus.full !== 1'b0 || bus.mem_req !== 1'b0 || bus.mem_addr !== '0 ||
        bus.mem_width !== '0 || bus.wb_en !== 1'b0 || bus.wb_tag !== '0 ||
        bus.wb_value !== '0) begin
      n_fail++;
      $display("FAIL %s: got full=%b req=%b addr=%h w=%b wb=%b tag=%0d val=%h; exp all zero",
               nm, bus.full, bus.mem_req, bus.mem_addr, bus.mem_width, bus.wb_en,
               bus.wb_tag, bus.wb_value);
    end
  endtask

  initial begin
    in_t tv;
    logic seen;

    // A: single LB, sign extension
    add("a_rst",      IR(),                          O0(0));
    add("a_alloc",    IA(4'd3, 32'h100, 3'b000, 0),  O0(0));
    add("a_commit",   IC(4'd3),                      O0(0));
    add("a_req",      IN(),                          OQ(0, 32'h100, 3'b001));
    add("a_req_hold", IN(),                          OQ(0, 32'h100, 3'b001));
    add("a_wb",       ID(32'h80),                    OW(0, 4'd3, 32'hFFFF_FF80));
    add("a_idle",     IN(),                          O0(0));

    // B: fill, drop when full, wrap
    add("b_rst", IR(), O0(0));
    for (int i = 0; i < 8; i++)
      add($sformatf("b_alloc%0d", i), IA(4'(i), 32'h200 + 32'(4 * i), 3'b010, 0), O0(i == 7));
    add("b_drop",      IA(4'd9, 32'h300, 3'b010, 0),  O0(1));
    add("b_commit0",   IC(4'd0),                      O0(1));
    add("b_req0",      IN(),                          OQ(1, 32'h200, 3'b100));
    add("b_wb0",       ID(32'h1234_5678),             OW(0, 4'd0, 32'h1234_5678));
    add("b_wrap",      IA(4'd10, 32'h400, 3'b010, 0), O0(1));
    add("b_drop2",     IA(4'd11, 32'h404, 3'b010, 0), O0(1));
    add("b_commit1",   IC(4'd1),                      O0(1));
    add("b_req1",      IN(),                          OQ(1, 32'h204, 3'b100));
    add("b_wb1",       ID(32'h55),                    OW(0, 4'd1, 32'h55));
    add("b_commit2",   IC(4'd2),                      O0(0));
    add("b_req2",      IN(),                          OQ(0, 32'h208, 3'b100));

    // C: LHU + LW committed in reverse order; reset abandons b_req2
    add("c_rst_midreq", IR(),                          O0(0));
    add("c_abandon",    IN(),                          O0(0));
    add("c_alloc2",     IA(4'd2, 32'h500, 3'b101, 0),  O0(0));
    add("c_alloc4",     IA(4'd4, 32'h504, 3'b010, 0),  O0(0));
    add("c_commit4",    IC(4'd4),                      O0(0));
`ifdef LQ_OOO_ISSUE_EN
    add("c_commit2",    IC(4'd2),                      OQ(0, 32'h504, 3'b100));
    add("c_wb4",        ID(32'hDEAD_BEEF),             OW(0, 4'd4, 32'hDEAD_BEEF));
    add("c_req2",       IN(),                          OQ(0, 32'h500, 3'b010));
    add("c_wb2",        ID(32'h8001),                  OW(0, 4'd2, 32'h0000_8001));
`else
    add("c_commit2",    IC(4'd2),                      O0(0));
    add("c_req2",       IN(),                          OQ(0, 32'h500, 3'b010));
    add("c_wb2",        ID(32'h8001),                  OW(0, 4'd2, 32'h0000_8001));
    add("c_req4",       IN(),                          OQ(0, 32'h504, 3'b100));
    add("c_wb4",        ID(32'hDEAD_BEEF),             OW(0, 4'd4, 32'hDEAD_BEEF));
`endif

    // D: flush during WAIT, drain, alloc in flush dropped, alloc during drain kept
    add("d_rst",        IR(),                          O0(0));
    add("d_alloc",      IA(4'd1, 32'h600, 3'b010, 1),  O0(0));
    add("d_req",        IN(),                          OQ(0, 32'h600, 3'b100));
    tv = IA(4'd5, 32'h650, 3'b010, 1);
    tv.fl = 1;
    add("d_flush",      tv,                            OQ(0, 32'h600, 3'b100));
    add("d_drain_alloc", IA(4'd7, 32'h700, 3'b100, 1), OQ(0, 32'h600, 3'b100));
    add("d_drain",      IN(),                          OQ(0, 32'h600, 3'b100));
    add("d_drain_done", ID(32'h99),                    O0(0));
    add("d_req7",       IN(),                          OQ(0, 32'h700, 3'b001));
    add("d_wb7",        ID(32'hF0),                    OW(0, 4'd7, 32'h0000_00F0));
    add("d_empty",      IN(),                          O0(0));

    // E: same-cycle alloc+commit, rdy low mid-WAIT ignores alloc and flush
    add("e_rst",        IR(),                          O0(0));
    add("e_alloc",      IA(4'd5, 32'h800, 3'b001, 1),  O0(0));
    add("e_req",        IN(),                          OQ(0, 32'h800, 3'b010));
    tv = IN(); tv.rdy = 0;
    add("e_hold0",      tv,                            OQ(0, 32'h800, 3'b010));
    tv = IA(4'd9, 32'h900, 3'b010, 1); tv.rdy = 0;
    add("e_hold1",      tv,                            OQ(0, 32'h800, 3'b010));
    tv = IN(); tv.rdy = 0; tv.fl = 1;
    add("e_hold2",      tv,                            OQ(0, 32'h800, 3'b010));
    tv = IN(); tv.rdy = 0;
    add("e_hold3",      tv,                            OQ(0, 32'h800, 3'b010));
    add("e_wb5",        ID(32'h8001),                  OW(0, 4'd5, 32'hFFFF_8001));
    add("e_idle0",      IN(),                          O0(0));
    add("e_idle1",      IN(),                          O0(0));

    // F: only the younger tag committed first
    add("f_rst",        IR(),                          O0(0));
    add("f_alloc1",     IA(4'd1, 32'hA00, 3'b010, 0),  O0(0));
    add("f_alloc2",     IA(4'd2, 32'hA04, 3'b010, 0),  O0(0));
    add("f_commit2",    IC(4'd2),                      O0(0));
`ifdef LQ_OOO_ISSUE_EN
    add("f_req2",       IN(),                          OQ(0, 32'hA04, 3'b100));
    add("f_commit1",    IC(4'd1),                      OQ(0, 32'hA04, 3'b100));
    add("f_wb2",        ID(32'h2),                     OW(0, 4'd2, 32'h2));
    add("f_req1",       IN(),                          OQ(0, 32'hA00, 3'b100));
    add("f_wb1",        ID(32'h1),                     OW(0, 4'd1, 32'h1));
`else
    add("f_blocked",    IN(),                          O0(0));
    add("f_commit1",    IC(4'd1),                      O0(0));
    add("f_req1",       IN(),                          OQ(0, 32'hA00, 3'b100));
    add("f_wb1",        ID(32'h1),                     OW(0, 4'd1, 32'h1));
    add("f_req2",       IN(),                          OQ(0, 32'hA04, 3'b100));
    add("f_wb2",        ID(32'h2),                     OW(0, 4'd2, 32'h2));
`endif

    // Power-on reset state
    drive(IN());
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    rst_n = 1'b1;

    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k].i);
      @(posedge clk);
      #1;
      check(vecs[k].name, vecs[k].o);
      rst_n = 1'b1;
    end

    // Asynchronous reset while a request is outstanding
    drive(IA(4'd3, 32'hB00, 3'b010, 1));
    @(posedge clk);
    #1;
    drive(IN());
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(posedge clk);
      #1;
      seen = bus.mem_req;
    end
    n_tests++;
    if (!seen || bus.mem_addr !== 32'hB00) begin
      n_fail++;
      $display("FAIL async_req: got req=%b addr=%h; exp req=1 addr=00000b00",
               bus.mem_req, bus.mem_addr);
    end
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset_midcycle");
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("async_abandoned", O0(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/load_queue.md
Name: load_queue

Overview:
- Parametrised successor to the load buffer: in-order circular queue holding address-resolved loads between the address unit and the data controller.
- Each load issues to memory only after the ROB marks it commit-safe; sign/zero extension is done in-block and the result is written back to the ROB.
- Adds configurable depth/widths, a full flag, commit-tag matching and a flush-while-in-flight drain state.

Parameters:
DEPTH, 8, entries; power of two, >= 2
PTR_W, 3, log2(DEPTH)
ADDR_W, 32, address width
DATA_W, 32, data width
ROB_W, 4, ROB tag width

Ports:
clk_in  in  1  clock
rst_n_in  in  1  asynchronous active-low reset
rdy_in  in  1  global enable; when low all state holds
alloc_en_in  in  1  address unit presents a load
alloc_addr_in  in  ADDR_W  effective address
alloc_tag_in  in  ROB_W  destination ROB tag
alloc_funct3_in  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
full_out  out  1  queue full; address unit must not allocate
rob_commit_en_in  in  1  ROB marks a tag commit-safe
rob_commit_tag_in  in  ROB_W  that tag
rob_flush_in  in  1  mispredict flush
mem_req_out  out  1  read request, held until mem_done_in
mem_addr_out  out  ADDR_W  read address
mem_width_out  out  3  001 byte, 010 half, 100 word
mem_done_in  in  1  one-cycle completion pulse
mem_data_in  in  DATA_W  raw data, zero-extended by the data controller
wb_en_out  out  1  one-cycle result pulse
wb_tag_out  out  ROB_W  result tag
wb_value_out  out  DATA_W  extended result

Behaviour:
- Reset (async, rst_n_in low): head=tail=0, count=0, all valid/ready clear, state IDLE; full_out=0, mem_req_out=0, mem_addr_out=0, mem_width_out=0, wb_en_out=0, wb_tag_out=0, wb_value_out=0. Reset mid-request abandons the request.
- rdy_in low: no state change; wb_en_out forced 0 the next edge.
- Allocation: on alloc_en_in with count<DEPTH, write entry[tail] {addr, tag, funct3, ready=0}, tail++ (wraps modulo DEPTH), count++. Alloc while full is dropped; full_out = (count==DEPTH), registered from next count.
- Commit: rob_commit_en_in sets ready on every valid entry whose tag matches. Commit and alloc of the same tag in the same cycle: new entry allocated with ready=1.
- FSM IDLE: if entry[head] valid and ready, latch its fields, go to WAIT; mem_req_out=1 from next cycle (earliest issue one cycle after ready is set). Address/width/req stable until done.
- WAIT: on mem_done_in: mem_req_out=0, next cycle wb_en_out=1, wb_tag_out=tag, wb_value_out=extended data; entry[head] freed, head++, count--, back to IDLE. Back-to-back issue: next head may raise req the cycle after done.
- Extension: LB sign-extends bit 7, LH bit 15, LBU/LHU zero-extend, LW passes through. Undefined funct3 treated as LW.
- Alloc and dealloc in the same cycle: count unchanged.
- Flush: rob_flush_in clears all entries, head=tail=0, count=0 next cycle. If state WAIT and done not yet seen: go DRAIN, keep mem_req_out=1 until mem_done_in, discard data (no wb), then IDLE. Flush in the same cycle as done: data discarded, state IDLE. Allocation in a flush cycle is dropped. Allocation allowed during DRAIN; no issue until IDLE.

Optional Feature:
LQ_OOO_ISSUE_EN
- Defined: IDLE selects the oldest valid ready entry anywhere in the queue (scan from head), not just the head. Freed holes are tracked by valid bits; head advances past contiguous invalid entries. count tracks valid entries, and full_out uses count.
- Undefined: strict in-order issue from head only, as described above.

Test Plan:
- Reset, alloc tag 3 addr 0x100 LB, commit tag 3, done data 0x80 -> req width 001 addr 0x100; wb_en_out pulse with tag 3, value 0xFFFFFF80.
- Alloc 8 loads with DEPTH=8 -> full_out=1; 9th alloc dropped; one completion -> full_out=0 and tail wraps to slot 0 on next alloc.
- Alloc LHU data 0x8001 and LW data 0xDEADBEEF, committed in reverse order -> in-order wb 0x00008001 then 0xDEADBEEF.
- Flush during WAIT; done arrives 3 cycles later -> no wb_en_out, req drops after done, queue empty, count=0.
- Same-cycle alloc and commit of tag 5 -> entry ready, req next cycle; rdy_in held low 4 cycles mid-WAIT -> outputs frozen, no lost result.
- LQ_OOO_ISSUE_EN: tags 1,2 allocated, only tag 2 committed -> tag 2 issues first; tag 1 issues after its commit.
